sseg_scan_driver: RTL

Parametrised, time-multiplexed seven-segment display driver for N BCD digits. It sits between the datapath (e.g. the Babbage engine result register) and the board's common-anode display. It latches a packed BCD word on a load strobe and applies it only at frame boundaries, so the display never shows a half-updated value. It scans one digit at a time at a programmable refresh rate, with per-digit decimal points, leading-zero blanking and an invalid-digit indicator.

---
 rtl/sseg_scan_driver.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/sseg_scan_driver.sv
// Time-multiplexed seven-segment driver: double-buffered BCD word, frame-aligned updates,
// leading-zero blanking and per-digit decimal points. Define SSEG_HEX_EN to show 10..15 as hex glyphs.
module sseg_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic                    load,
  input  logic                    blank_lz,
  output logic [7:0]              sseg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int PRE_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW    = 4 * NUM_DIGITS;

  localparam logic [PRE_W-1:0]      PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [7:0]            SEG_OFF  = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{ACTIVE_LOW != 0}};

  logic [PRE_W-1:0]      presc;
  logic [IDX_W-1:0]      idx;
  logic [DW-1:0]         pend_data, shad_data;
  logic [NUM_DIGITS-1:0] pend_dp, shad_dp;
  logic                  wrap, boundary;

  // Active-low glyph for one digit, decimal point off.
  function automatic logic [7:0] seg_decode(input logic [3:0] v);
    logic [7:0] s;
    case (v)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
`ifdef SSEG_HEX_EN
      4'd10:   s = 8'h88;
      4'd11:   s = 8'h83;
      4'd12:   s = 8'hC6;
      4'd13:   s = 8'hA1;
      4'd14:   s = 8'h86;
      4'd15:   s = 8'h8E;
`endif
      default: s = 8'hBF;
    endcase
    return s;
  endfunction

  assign wrap       = (presc == PRE_LAST);
  assign boundary   = wrap && (idx == IDX_LAST);
  assign frame_done = boundary;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= '0;
    end else begin
      presc <= wrap ? '0 : presc + PRE_W'(1);
      if (wrap) idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    end
  end

  // Shadow only changes at a frame boundary; a coincident load bypasses pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_data <= '0;
      pend_dp   <= '0;
      shad_data <= '0;
      shad_dp   <= '0;
    end else begin
      if (load) begin
        pend_data <= data;
        pend_dp   <= dp_mask;
      end
      if (boundary) begin
        shad_data <= load ? data : pend_data;
        shad_dp   <= load ? dp_mask : pend_dp;
      end
    end
  end

  logic [NUM_DIGITS-1:0] blank, an_on, an_p0;
  logic                  above_blank, cur_dp, cur_blank;
  logic [3:0]            cur_digit;
  logic [7:0]            seg_lit, seg_p0;

  // Stage p0: digit select, blanking and decode ahead of the output register.
  always_comb begin
    blank       = '0;
    above_blank = blank_lz;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      blank[k]    = above_blank && (shad_data[4*k +: 4] == 4'd0) && !shad_dp[k];
      above_blank = blank[k];
    end

    an_on     = '0;
    cur_digit = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        an_on[k]  = 1'b1;
        cur_digit = shad_data[4*k +: 4];
        cur_dp    = shad_dp[k];
        cur_blank = blank[k];
      end
    end

    seg_lit = cur_blank ? 8'hFF : (seg_decode(cur_digit) & {~cur_dp, 7'h7F});
    if (ACTIVE_LOW != 0) begin
      seg_p0 = seg_lit;
      an_p0  = ~an_on;
    end else begin
      seg_p0 = ~seg_lit;
      an_p0  = an_on;
    end
  end

  // Stage p1: registered display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sseg <= SEG_OFF;
      an   <= AN_OFF;
    end else begin
      sseg <= seg_p0;
      an   <= an_p0;
    end
  end

endmodule
